count_ctrl: RTL and testbench
=============================

# count_ctrl

Run/pause/step controller that sequences the 4-bit display counter on the board. It divides the 50 MHz clock into count ticks and turns button events (start, stop, step) into single-cycle enable and clear strobes for the counter. It watches the counter value against a terminal count and either wraps or halts there. It sits between the board switches/keys and the counter, whose output still feeds the 7-segment decoder.

## Interface
- DIV, default 50_000_000: clk cycles per count tick; must be at least 2. The prescaler is $clog2(DIV) bits wide.
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- start  in  1  level from a key or switch, asynchronous to clk; only its rising edge is used
- stop  in  1  level, asynchronous; only its rising edge is used
- step  in  1  level, asynchronous; only its rising edge is used
- wrap  in  1  1: count past terminal back to 0; 0: halt at terminal
- terminal  in  4  terminal count value, sampled live
- count_q  in  4  current counter value (feedback)
- cnt_en  out  1  one-cycle increment strobe to the counter
- cnt_clr  out  1  one-cycle clear strobe to the counter (synchronous clear)
- running  out  1  high in state RUN
- done  out  1  high in state DONE

## Operation
- Input conditioning:
  - Each of start, stop and step passes through 2 synchronizer flops plus a history flop.
  - The internal event is s2 & ~s3, which gives exactly one event per rising edge. Holding a level produces no repeats.
- Event priority when events coincide in one cycle: stop > start > step. Lower-priority events in that cycle are dropped.
- States: IDLE, RUN, PAUSE, DONE.
- Prescaler `pre`:
  - Advances only in RUN. Goes from DIV-1 to 0 and asserts `tick` while pre == DIV-1 in RUN.
  - Holds its value in PAUSE.
  - Is cleared to 0 on entry to RUN from IDLE or DONE.
- Advance action, taken on a tick or an accepted step, with terminal compared to count_q for equality only:
  - count_q != terminal: pulse cnt_en.
  - count_q == terminal and wrap=1: pulse cnt_clr. The counter goes to 0, and that counts as the advance.
  - count_q == terminal and wrap=0: no strobe; go to DONE.
- Transitions:
  - IDLE: start → RUN. step → advance once, stay IDLE (or go to DONE per the rule above). stop is ignored.
  - RUN: stop → PAUSE. start and step are ignored. A tick performs the advance action.
  - PAUSE: start → RUN, resuming from the held pre. step → advance once, stay PAUSE (or DONE). stop is ignored.
  - DONE: start → pulse cnt_clr and go to RUN with pre=0. stop → IDLE. step is ignored.
- cnt_en and cnt_clr are never high in the same cycle. Each is high for exactly one cycle per action.
- Terminal change mid-run takes effect at the next comparison. With wrap=0 and count_q already past terminal, the counter runs on, wraps at 15→0 naturally, and halts when it reaches terminal.

## Timing
- All outputs are registered.
- Reset values: cnt_en=0, running=0, done=0, state=IDLE, pre=0, synchronizer flops=0.
- cnt_clr=1 in every cycle reset is sampled high, and 0 from the first cycle after reset is released. This clears the counter alongside the controller.
- Input latency: the first clk edge sampling an input high is edge k. The event is acted on at edge k+2, so the state and strobe are visible after edge k+2.
- In RUN, a tick occurs every DIV cycles. The strobe appears the cycle after pre == DIV-1, i.e. the strobe register is loaded on the same edge where pre wraps to 0.
- count_q is expected to reflect a strobe one cycle after that strobe. The next comparison is at least DIV (≥2) cycles later, so feedback latency is safe.
- Reset mid-RUN or mid-strobe: at the next edge, state=IDLE, cnt_en=0, cnt_clr=1, and pre=0. No partial strobe follows.

## Test plan
- Reset then run (DIV=4, terminal=9, wrap=1, counter model attached):
  - Pulse start.
  - running=1 two edges after start is first sampled.
  - cnt_en pulses every 4 cycles.
  - count_q goes 0..9, then cnt_clr and 0, with no cnt_en in that slot.
- Halt at terminal (DIV=4, terminal=3, wrap=0), start:
  - Counter reaches 3, then done=1 and running=0 at the next tick with no strobe.
  - Start again: one cnt_clr, counter=0, running=1, pre restarts at 0.
- Pause/resume/step (DIV=8):
  - Stop with pre=5: PAUSE, pre holds 5, no strobes for 50 cycles.
  - Three step edges: exactly 3 cnt_en pulses.
  - Start: the first tick arrives 3 cycles after resume.
- Simultaneous events: start and stop rising on the same edge while in RUN → PAUSE. Start and step on the same edge in IDLE → RUN with no cnt_en from the step.
- Held inputs and reset:
  - start held high for 100 cycles: exactly one start event.
  - reset asserted while cnt_en is high: next cycle cnt_en=0, cnt_clr=1, state IDLE, and count_q=0 after the counter responds.
- Terminal change mid-run (wrap=0): count_q=7, terminal changed to 2 → count continues 8..15, 0, 1, 2, then DONE.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/step sequencer for the 4-bit display counter.
// Ports: clk/reset (50 MHz, sync active-high); start/stop/step async levels, rising edge = event;
// wrap/terminal select wrap-or-halt at the terminal count; count_q is counter feedback;
// cnt_en/cnt_clr are one-cycle strobes to the counter; running/done flag states RUN/DONE.
module count_ctrl #(
  parameter int DIV = 50_000_000,
  localparam int PW = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       wrap,
  input  logic [3:0] terminal,
  input  logic [3:0] count_q,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0] s1_q, s2_q, s3_q;
  logic cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d, running_q, running_d, done_q, done_d;
  logic ev_start, ev_stop, ev_step, tick, at_term, adv;
  // sync bits are {start, stop, step}; stop beats start beats step
  assign ev_stop  = s2_q[1] & ~s3_q[1];
  assign ev_start = s2_q[2] & ~s3_q[2] & ~ev_stop;
  assign ev_step  = s2_q[0] & ~s3_q[0] & ~ev_stop & ~(s2_q[2] & ~s3_q[2]);
  assign tick     = (state_q == RUN) && (pre_q == PW'(DIV - 1));
  assign at_term  = count_q == terminal;
  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign running  = running_q;
  assign done     = done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      s1_q      <= {start, stop, step};
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    adv = 1'b0;
    case (state_q)
      IDLE:    if (ev_start) state_d = RUN; else adv = ev_step;
      RUN:     if (ev_stop) state_d = PAUSE; else adv = tick;
      PAUSE:   if (ev_start) state_d = RUN; else adv = ev_step;
      default: if (ev_start) state_d = RUN; else if (ev_stop) state_d = IDLE;
    endcase
    if (adv && at_term && !wrap) state_d = DONE;
    // a stop freezes pre where it stands so resume continues the same period
    pre_d = (state_q == RUN && !ev_stop) ? (tick ? '0 : pre_q + PW'(1)) :
            (state_q != PAUSE && state_d == RUN) ? '0 : pre_q;
  end
  always_comb begin
    cnt_en_d  = adv & ~at_term;
    cnt_clr_d = (adv & at_term & wrap) | ((state_q == DONE) & ev_start);
    running_d = state_d == RUN;
    done_d    = state_d == DONE;
  end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: scoreboard bench for count_ctrl with an attached 4-bit counter model.
module tb_count_ctrl;
  localparam int DIV = 4;
  localparam int S_RUN = 0, S_DONE = 1, S_CNT = 2, S_CLR = 3, S_EN = 4;
  logic clk = 0, reset = 1, start = 0, stop = 0, step = 0, wrap = 1;
  logic [3:0] terminal = 4'd9, count_q = 4'hA;
  logic cnt_en, cnt_clr, running, done;
  logic rst_edge = 1, end_req = 0, fin = 0;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic clr; int at;} strobe_t;
  typedef struct {int at; int sel; logic [3:0] v;} lv_t;
  strobe_t sb[$];
  lv_t lv[$];
  string nm[5] = '{"running", "done", "count_q", "cnt_clr", "cnt_en"};

  count_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .wrap(wrap), .terminal(terminal), .count_q(count_q),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edge <= reset;
    count_q <= cnt_clr ? 4'd0 : cnt_en ? count_q + 4'd1 : count_q;
  end

  always @(negedge clk) begin
    strobe_t e;
    lv_t l;
    logic [3:0] act;
    if (!rst_edge && (cnt_en || cnt_clr)) begin
      checks++;
      if (cnt_en && cnt_clr) begin
        errors++;
        $display("FAIL strobe_both: cnt_en and cnt_clr both high at cycle %0d, required one", cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: %s at cycle %0d, required none", cnt_clr ? "cnt_clr" : "cnt_en", cyc);
      end else begin
        e = sb.pop_front();
        if (e.clr !== cnt_clr || e.at != cyc) begin
          errors++;
          $display("FAIL strobe: got %s at cycle %0d, required %s at cycle %0d",
                   cnt_clr ? "cnt_clr" : "cnt_en", cyc, e.clr ? "cnt_clr" : "cnt_en", e.at);
        end
      end
    end
    while (lv.size() > 0 && lv[0].at <= cyc) begin
      l = lv.pop_front();
      act = l.sel == S_RUN ? {3'b0, running} : l.sel == S_DONE ? {3'b0, done} :
            l.sel == S_CNT ? count_q : l.sel == S_CLR ? {3'b0, cnt_clr} : {3'b0, cnt_en};
      checks++;
      if (l.at != cyc || act !== l.v) begin
        errors++;
        $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d", nm[l.sel], act, cyc, l.v, l.at);
      end
    end
    if (end_req && !fin) begin
      checks++;
      if (sb.size() + lv.size() != 0) begin
        errors++;
        $display("FAIL pending: %0d strobes and %0d level checks never seen, required 0", sb.size(), lv.size());
      end
      fin = 1;
    end
  end

  task automatic expect_lv(input int at, input int sel, input logic [3:0] v);
    int i = 0;
    lv_t e;
    e.at = at; e.sel = sel; e.v = v;
    while (i < lv.size() && lv[i].at <= at) i++;
    lv.insert(i, e);
  endtask

  task automatic expect_sb(input logic clr, input int at);
    strobe_t e;
    e.clr = clr; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    int t;
    reset = 1; start = 0; stop = 0; step = 0;
    t = cyc;
    expect_lv(t + 1, S_CLR, 1);
    expect_lv(t + 1, S_EN, 0);
    expect_lv(t + 2, S_RUN, 0);
    expect_lv(t + 2, S_DONE, 0);
    wait_cyc(t + 3);
    reset = 0;
    expect_lv(t + 4, S_CLR, 0);
    expect_lv(t + 4, S_CNT, 0);
    wait_cyc(t + 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    #1;
    // run with wrap at 9
    do_reset();
    terminal = 4'd9; wrap = 1; t = cyc; start = 1;
    expect_lv(t + 2, S_RUN, 0);
    expect_lv(t + 3, S_RUN, 1);
    for (int i = 0; i < 9; i++) expect_sb(0, t + 7 + 4 * i);
    expect_sb(1, t + 43);
    expect_sb(0, t + 47);
    expect_lv(t + 42, S_CNT, 9);
    expect_lv(t + 43, S_EN, 0);
    expect_lv(t + 44, S_CNT, 0);
    wait_cyc(t + 1); start = 0;
    wait_cyc(t + 45); stop = 1;
    expect_lv(t + 48, S_RUN, 0);
    expect_lv(t + 48, S_CNT, 1);
    wait_cyc(t + 46); stop = 0;
    wait_cyc(t + 50);
    // halt at terminal 3, then restart from DONE
    do_reset();
    terminal = 4'd3; wrap = 0; t = cyc; start = 1;
    for (int i = 0; i < 3; i++) expect_sb(0, t + 7 + 4 * i);
    expect_lv(t + 18, S_RUN, 1);
    expect_lv(t + 18, S_DONE, 0);
    expect_lv(t + 19, S_RUN, 0);
    expect_lv(t + 19, S_DONE, 1);
    expect_lv(t + 19, S_CNT, 3);
    wait_cyc(t + 1); start = 0;
    wait_cyc(t + 21); t2 = cyc; start = 1;
    expect_sb(1, t2 + 3);
    for (int i = 0; i < 3; i++) expect_sb(0, t2 + 7 + 4 * i);
    expect_lv(t2 + 3, S_RUN, 1);
    expect_lv(t2 + 3, S_DONE, 0);
    expect_lv(t2 + 4, S_CNT, 0);
    expect_lv(t2 + 19, S_DONE, 1);
    wait_cyc(t2 + 1); start = 0;
    wait_cyc(t2 + 20);
    // pause with pre=2, three steps, resume
    do_reset();
    terminal = 4'd15; wrap = 1; t = cyc; start = 1;
    expect_sb(0, t + 7);
    wait_cyc(t + 1); start = 0;
    wait_cyc(t + 7); stop = 1;
    expect_lv(t + 10, S_RUN, 0);
    expect_lv(t + 10, S_CNT, 1);
    expect_lv(t + 60, S_RUN, 0);
    expect_lv(t + 60, S_CNT, 1);
    wait_cyc(t + 8); stop = 0;
    for (int j = 0; j < 3; j++) begin
      wait_cyc(t + 60 + 5 * j); step = 1;
      expect_sb(0, t + 63 + 5 * j);
      wait_cyc(t + 61 + 5 * j); step = 0;
    end
    expect_lv(t + 76, S_CNT, 4);
    expect_lv(t + 76, S_RUN, 0);
    wait_cyc(t + 80); start = 1;
    expect_lv(t + 83, S_RUN, 1);
    expect_lv(t + 84, S_EN, 0);
    expect_sb(0, t + 85);
    expect_sb(0, t + 89);
    wait_cyc(t + 81); start = 0;
    wait_cyc(t + 90);
    // start and stop together in RUN
    do_reset();
    t = cyc; start = 1;
    expect_sb(0, t + 7);
    expect_sb(0, t + 11);
    wait_cyc(t + 1); start = 0;
    wait_cyc(t + 9); start = 1; stop = 1;
    expect_lv(t + 12, S_RUN, 0);
    expect_lv(t + 25, S_RUN, 0);
    expect_lv(t + 25, S_CNT, 2);
    wait_cyc(t + 10); start = 0; stop = 0;
    wait_cyc(t + 26);
    // start and step together in IDLE
    do_reset();
    t = cyc; start = 1; step = 1;
    expect_lv(t + 3, S_RUN, 1);
    expect_lv(t + 6, S_CNT, 0);
    expect_lv(t + 8, S_CNT, 1);
    expect_sb(0, t + 7);
    wait_cyc(t + 1); start = 0; step = 0;
    wait_cyc(t + 9);
    // start held for 100 cycles gives one event
    do_reset();
    t = cyc; start = 1;
    expect_lv(t + 3, S_RUN, 1);
    for (int i = 0; i < 5; i++) expect_sb(0, t + 7 + 4 * i);
    wait_cyc(t + 21); stop = 1;
    wait_cyc(t + 22); stop = 0;
    expect_lv(t + 24, S_RUN, 0);
    expect_lv(t + 60, S_RUN, 0);
    expect_lv(t + 100, S_RUN, 0);
    expect_lv(t + 100, S_CNT, 5);
    expect_lv(t + 105, S_RUN, 0);
    wait_cyc(t + 100); start = 0;
    wait_cyc(t + 106);
    // reset while cnt_en is high
    do_reset();
    t = cyc; start = 1;
    expect_sb(0, t + 7);
    wait_cyc(t + 1); start = 0;
    wait_cyc(t + 7); reset = 1;
    expect_lv(t + 7, S_EN, 1);
    expect_lv(t + 8, S_EN, 0);
    expect_lv(t + 8, S_CLR, 1);
    expect_lv(t + 8, S_RUN, 0);
    expect_lv(t + 8, S_DONE, 0);
    expect_lv(t + 9, S_CNT, 0);
    wait_cyc(t + 9); reset = 0;
    expect_lv(t + 10, S_CLR, 0);
    wait_cyc(t + 12);
    // terminal lowered below count_q mid-run, wrap=0
    do_reset();
    terminal = 4'd9; wrap = 0; t = cyc; start = 1;
    for (int i = 0; i < 18; i++) expect_sb(0, t + 7 + 4 * i);
    expect_lv(t + 32, S_CNT, 7);
    wait_cyc(t + 1); start = 0;
    wait_cyc(t + 33); terminal = 4'd2;
    expect_lv(t + 78, S_DONE, 0);
    expect_lv(t + 78, S_RUN, 1);
    expect_lv(t + 79, S_DONE, 1);
    expect_lv(t + 79, S_RUN, 0);
    expect_lv(t + 79, S_CNT, 2);
    expect_lv(t + 90, S_CNT, 2);
    wait_cyc(t + 92);
    end_req = 1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
